addsub_serial: RTL and testbench

Multi-cycle, parametrised two's-complement adder/subtractor that processes WIDTH-bit operands DIGIT bits per clock. It produces the sum/difference plus the `cout`, `overflow`, `negativo` and `cero` flags. Operands arrive through a valid/ready handshake, and results are held under a second valid/ready handshake. The block sits in the datapath wherever a full-width combinational adder is too large or too slow, trading latency for area.

---
 rtl/addsub_serial.sv | 210 +++++++++++++++++++++
 tb/tb_addsub_serial.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial two's-complement adder/subtractor.
//
// Processes WIDTH-bit operands DIGIT bits per clock, least significant digit first,
// so a result takes N = WIDTH/DIGIT cycles. Operands are accepted through an
// in_valid_i/in_ready_o handshake. The result and flags are held under an
// out_valid_o/out_ready_i handshake.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   flush_i      synchronous abort; returns to idle and drops any operation or held result
//   in_valid_i   operands valid
//   in_ready_o   block idle, operands can be accepted
//   a_i, b_i     operands
//   cin_i        carry in for addition (ignored when res_i = 1)
//   res_i        0: a + b + cin, 1: a - b (as a + ~b + 1)
//   out_valid_o  result valid
//   out_ready_i  consumer takes the result
//   s_o          result modulo 2^WIDTH
//   cout_o       carry out of bit WIDTH-1 (for subtraction 1 = no borrow)
//   overflow_o   signed overflow (carry into MSB xor carry out of MSB)
//   negativo_o   s_o[WIDTH-1] and subtraction
//   cero_o       s_o == 0
module addsub_serial #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic             res_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] s_o,
    output logic             cout_o,
    output logic             overflow_o,
    output logic             negativo_o,
    output logic             cero_o
);

    localparam int unsigned N    = WIDTH / DIGIT;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(N - 1);

    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_err
        $error("addsub_serial: illegal WIDTH/DIGIT combination");
    end

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e state_q, state_d;

    // Operand shift registers; b_q already holds ~b for subtraction.
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] a_shr, b_shr;

    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             res_q, res_d;

    logic cout_q, cout_d;
    logic ovf_q, ovf_d;
    logic neg_q, neg_d;
    logic cero_q, cero_d;

    logic [DIGIT:0] digit_sum;
    logic           msb_cin;
    logic           last_digit;

    // One digit of the ripple: low DIGIT bits of each operand plus the stored carry.
    assign digit_sum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]}
                     + {{DIGIT{1'b0}}, carry_q};

    // Carry into the top bit of the digit recovered from sum = a ^ b ^ carry_in.
    // On the last digit this is the carry into bit WIDTH-1.
    assign msb_cin = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ digit_sum[DIGIT-1];

    assign last_digit = (cnt_q == LastCnt);

    if (DIGIT < WIDTH) begin : g_shift
        assign a_shr = {{DIGIT{1'b0}}, a_q[WIDTH-1:DIGIT]};
        assign b_shr = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
    end else begin : g_no_shift
        assign a_shr = '0;
        assign b_shr = '0;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        neg_d   = neg_q;
        cero_d  = cero_q;

        if (flush_i) begin
            // Same visible state as reset; operands are don't-care once idle.
            state_d = StIdle;
            sum_d   = '0;
            cnt_d   = '0;
            carry_d = 1'b0;
            cout_d  = 1'b0;
            ovf_d   = 1'b0;
            neg_d   = 1'b0;
            cero_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid_i) begin
                        state_d = StRun;
                        a_d     = a_i;
                        b_d     = res_i ? ~b_i : b_i;
                        res_d   = res_i;
                        carry_d = res_i | cin_i;
                        cnt_d   = '0;
                        sum_d   = '0;
                        cout_d  = 1'b0;
                        ovf_d   = 1'b0;
                        neg_d   = 1'b0;
                        cero_d  = 1'b0;
                    end
                end
                StRun: begin
                    sum_d[cnt_q*DIGIT +: DIGIT] = digit_sum[DIGIT-1:0];
                    a_d     = a_shr;
                    b_d     = b_shr;
                    carry_d = digit_sum[DIGIT];
                    cnt_d   = cnt_q + CntW'(1);
                    if (last_digit) begin
                        // Flags only from the completed result and final carries.
                        state_d = StDone;
                        cnt_d   = '0;
                        cout_d  = digit_sum[DIGIT];
                        ovf_d   = msb_cin ^ digit_sum[DIGIT];
                        neg_d   = sum_d[WIDTH-1] & res_q;
                        cero_d  = (sum_d == '0);
                    end
                end
                StDone: begin
                    if (out_ready_i) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            res_q   <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            neg_q   <= 1'b0;
            cero_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            neg_q   <= neg_d;
            cero_q  <= cero_d;
        end
    end

    // Outputs are decodes of flops only.
    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign s_o         = sum_q;
    assign cout_o      = cout_q;
    assign overflow_o  = ovf_q;
    assign negativo_o  = neg_q;
    assign cero_o      = cero_q;

endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: four parameterisations of addsub_serial driven in lockstep with
// shared operands, checked against an integer-arithmetic reference model.
module tb_addsub_serial;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        cin;
    logic        res;
    logic [3:0]  ord;

    logic [3:0]  ir_w, ov_w, cout_w, ovf_w, neg_w, cero_w;
    logic [15:0] s0, s1, s2;
    logic [5:0]  s3;

    int n_checks = 0;
    int n_errors = 0;
    logic [19:0] last0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(16), .DIGIT(4)) u_dut_w16_d4 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(ir_w[0]), .a_i(a_in), .b_i(b_in), .cin_i(cin), .res_i(res),
        .out_valid_o(ov_w[0]), .out_ready_i(ord[0]), .s_o(s0), .cout_o(cout_w[0]),
        .overflow_o(ovf_w[0]), .negativo_o(neg_w[0]), .cero_o(cero_w[0])
    );

    addsub_serial #(.WIDTH(16), .DIGIT(1)) u_dut_w16_d1 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(ir_w[1]), .a_i(a_in), .b_i(b_in), .cin_i(cin), .res_i(res),
        .out_valid_o(ov_w[1]), .out_ready_i(ord[1]), .s_o(s1), .cout_o(cout_w[1]),
        .overflow_o(ovf_w[1]), .negativo_o(neg_w[1]), .cero_o(cero_w[1])
    );

    addsub_serial #(.WIDTH(16), .DIGIT(16)) u_dut_w16_d16 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(ir_w[2]), .a_i(a_in), .b_i(b_in), .cin_i(cin), .res_i(res),
        .out_valid_o(ov_w[2]), .out_ready_i(ord[2]), .s_o(s2), .cout_o(cout_w[2]),
        .overflow_o(ovf_w[2]), .negativo_o(neg_w[2]), .cero_o(cero_w[2])
    );

    addsub_serial #(.WIDTH(6), .DIGIT(3)) u_dut_w6_d3 (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(ir_w[3]), .a_i(a_in[5:0]), .b_i(b_in[5:0]), .cin_i(cin), .res_i(res),
        .out_valid_o(ov_w[3]), .out_ready_i(ord[3]), .s_o(s3), .cout_o(cout_w[3]),
        .overflow_o(ovf_w[3]), .negativo_o(neg_w[3]), .cero_o(cero_w[3])
    );

    function automatic int w_of(input int i);
        return (i == 3) ? 6 : 16;
    endfunction

    function automatic int n_of(input int i);
        case (i)
            0:       return 4;
            1:       return 16;
            2:       return 1;
            default: return 2;
        endcase
    endfunction

    // {in_ready, out_valid, cero, negativo, overflow, cout, s}
    function automatic logic [21:0] obs(input int i);
        logic [15:0] s;
        case (i)
            0:       s = s0;
            1:       s = s1;
            2:       s = s2;
            default: s = {10'd0, s3};
        endcase
        return {ir_w[i], ov_w[i], cero_w[i], neg_w[i], ovf_w[i], cout_w[i], s};
    endfunction

    // Reference: {cero, negativo, overflow, cout, s} from plain integer arithmetic.
    function automatic logic [19:0] model(input int w, input logic [15:0] a,
                                          input logic [15:0] b, input logic c,
                                          input logic r);
        longint m, half, ua, ub, bb, full, s, sa, sb, sr;
        logic [19:0] o;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(a) & m;
        ub   = longint'(b) & m;
        bb   = r ? (~ub & m) : ub;
        full = ua + bb + (r ? longint'(1) : longint'(c));
        s    = full & m;
        sa   = (ua >= half) ? ua - 2 * half : ua;
        sb   = (ub >= half) ? ub - 2 * half : ub;
        sr   = r ? sa - sb : sa + sb + longint'(c);
        o        = '0;
        o[15:0]  = s[15:0];
        o[16]    = ((full >> w) & 1) != 0;
        o[17]    = (sr < -half) || (sr >= half);
        o[18]    = r && (s >= half);
        o[19]    = (s == 0);
        return o;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        for (int i = 0; i < 4; i++) begin
            check_eq(tag, 32'(obs(i)), {10'd0, 2'b10, 20'h0});
        end
    endtask

    function automatic logic [15:0] pick();
        case ($urandom % 8)
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Must be entered just after a rising edge with every DUT idle.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                          input logic r, input bit stall);
        logic [19:0] exp [4];
        bit seen [4];
        bit done [4];
        bit post [4];
        int cyc, hold, n_post, n_seen;
        logic [21:0] o;
        for (int i = 0; i < 4; i++) begin
            exp[i]  = model(w_of(i), a, b, c, r);
            seen[i] = 1'b0;
            done[i] = 1'b0;
            post[i] = 1'b0;
        end
        ord      = '0;
        a_in     = a;
        b_in     = b;
        cin      = c;
        res      = r;
        in_valid = 1'b1;
        @(posedge clk); #1;
        // Garbage on the inputs while running must not matter.
        in_valid = 1'b0;
        a_in     = 16'($urandom);
        b_in     = 16'($urandom);
        cin      = 1'($urandom);
        res      = 1'($urandom);
        cyc      = 0;
        hold     = 0;
        n_post   = 0;
        while (n_post < 4 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            for (int i = 0; i < 4; i++) begin
                o = obs(i);
                if (post[i]) begin
                    // nothing left to do for this instance
                end else if (done[i]) begin
                    check_eq("idle_after_ack", 32'(o[21:20]), 32'h2);
                    ord[i]  = 1'b0;
                    post[i] = 1'b1;
                    n_post++;
                end else if (o[20]) begin
                    if (!seen[i]) begin
                        seen[i] = 1'b1;
                        check_eq("latency", cyc, n_of(i));
                        if (i == 0) last0 = o[19:0];
                    end
                    check_eq("result", 32'(o), 32'({2'b01, exp[i]}));
                    if (stall) begin
                        ord[i] = 1'b0;
                    end else begin
                        ord[i]  = ($urandom % 3) != 0;
                        done[i] = ord[i];
                    end
                end else if (seen[i]) begin
                    check_eq("valid_hold", 32'(o[20]), 32'h1);
                end
            end
            n_seen = 0;
            for (int i = 0; i < 4; i++) n_seen += int'(seen[i]);
            if (stall && n_seen == 4) begin
                hold++;
                if (hold <= 5) begin
                    in_valid = 1'b1;
                    a_in     = 16'($urandom);
                    b_in     = 16'($urandom);
                end else begin
                    in_valid = 1'b0;
                    for (int i = 0; i < 4; i++) begin
                        ord[i]  = 1'b1;
                        done[i] = 1'b1;
                    end
                end
            end
        end
        in_valid = 1'b0;
        check_eq("op_completed", n_post, 4);
    endtask

    task automatic abort_test(input bit use_flush);
        bit saw_valid;
        ord      = '0;
        a_in     = pick();
        b_in     = pick();
        cin      = 1'($urandom);
        res      = 1'($urandom);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        if (!use_flush) begin
            rst_n = 1'b0;
            #1;
            check_zero("reset_abort");
            @(posedge clk); #1;
            check_zero("reset_hold");
            #2 rst_n = 1'b1;
            @(posedge clk); #1;
        end else begin
            flush    = 1'b1;
            in_valid = 1'b1;
            a_in     = 16'h1234;
            @(posedge clk); #1;
            flush    = 1'b0;
            in_valid = 1'b0;
            check_zero("flush_abort");
        end
        saw_valid = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (ov_w != 4'h0) saw_valid = 1'b1;
        end
        check_eq("no_valid_after_abort", 32'(saw_valid), 32'h0);
    endtask

    initial begin
        rst_n    = 1'b1;
        flush    = 1'b0;
        in_valid = 1'b0;
        a_in     = '0;
        b_in     = '0;
        cin      = 1'b0;
        res      = 1'b0;
        ord      = '0;
        last0    = '0;
        #1 rst_n = 1'b0;
        #2;
        check_zero("reset_state");
        @(posedge clk); #1;
        check_zero("reset_state_clocked");
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
        check_eq("dir_7fff_plus_1", 32'(last0), 32'({1'b0, 1'b0, 1'b1, 1'b0, 16'h8000}));
        run_op(16'h0005, 16'h0005, 1'b0, 1'b1, 1'b0);
        check_eq("dir_5_minus_5", 32'(last0), 32'({1'b1, 1'b0, 1'b0, 1'b1, 16'h0000}));
        run_op(16'h0003, 16'h0005, 1'b0, 1'b1, 1'b0);
        check_eq("dir_3_minus_5", 32'(last0), 32'({1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFE}));
        run_op(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0);
        check_eq("dir_ffff_plus_cin", 32'(last0), 32'({1'b1, 1'b0, 1'b0, 1'b1, 16'h0000}));
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
        check_eq("dir_8000_minus_1", 32'(last0), 32'({1'b0, 1'b0, 1'b1, 1'b1, 16'h7FFF}));

        run_op(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b1);
        run_op(pick(), pick(), 1'($urandom), 1'($urandom), 1'b0);

        abort_test(1'b0);
        abort_test(1'b1);

        for (int k = 0; k < 1000; k++) begin
            run_op(pick(), pick(), 1'($urandom), 1'($urandom), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
